// File: rtl/heart_assemble_pkg.sv
// Shared constants for the self-assembling heart: fragment flight table and FSM states.
package heart_assemble_pkg;
  localparam int NUM_FRAG = 6;
  localparam int CENTER_X = 512;
  localparam int CENTER_Y = 384;

  typedef enum logic [1:0] {IDLE, ASSEMBLE, HOLD} state_t;

  localparam logic [10:0] START_X [NUM_FRAG] = '{11'd0, 11'd992, 11'd0, 11'd496, 11'd992, 11'd496};
  localparam logic [9:0]  START_Y [NUM_FRAG] = '{10'd0, 10'd0, 10'd384, 10'd0, 10'd384, 10'd736};
  // Targets tile a 3-wide heart around centre, leaving the top-middle slot as the notch
  localparam logic [10:0] TGT_X [NUM_FRAG] = '{11'(CENTER_X - 48), 11'(CENTER_X + 16), 11'(CENTER_X - 48),
                                               11'(CENTER_X - 16), 11'(CENTER_X + 16), 11'(CENTER_X - 16)};
  localparam logic [9:0]  TGT_Y [NUM_FRAG] = '{10'(CENTER_Y - 32), 10'(CENTER_Y - 32), 10'(CENTER_Y),
                                               10'(CENTER_Y), 10'(CENTER_Y), 10'(CENTER_Y + 32)};
  localparam logic [10:0] STEP [NUM_FRAG] = '{11'd4, 11'd4, 11'd8, 11'd4, 11'd8, 11'd2};

  function automatic logic [10:0] step_toward(input logic [10:0] pos, input logic [10:0] tgt,
                                              input logic [10:0] step);
    if (pos < tgt) return ((tgt - pos) <= step) ? tgt : pos + step;
    else           return ((pos - tgt) <= step) ? tgt : pos - step;
  endfunction

  function automatic logic within_step(input logic [10:0] pos, input logic [10:0] tgt,
                                       input logic [10:0] step);
    if (pos < tgt) return (tgt - pos) <= step;
    else           return (pos - tgt) <= step;
  endfunction
endpackage

// File: rtl/heart_assemble_if.sv
// Raster-side bus of the heart sprite: scan position in, pixel/status out.
interface heart_assemble_if;
  logic [10:0] hcount_in;
  logic [9:0]  vcount_in;
  logic        valid_in;
  logic        start;
  logic        in_sprite;
  logic [11:0] pixel_out;
  logic        done;

  modport master (output hcount_in, vcount_in, valid_in, start,
                  input  in_sprite, pixel_out, done);
  modport slave  (input  hcount_in, vcount_in, valid_in, start,
                  output in_sprite, pixel_out, done);
endinterface

// File: rtl/heart_fragment_mover.sv
// One fragment's top-left position, stepped toward its target on each tick without overshoot.
module heart_fragment_mover
  import heart_assemble_pkg::*;
#(
  parameter logic [10:0] P_START_X = 11'd0,
  parameter logic [9:0]  P_START_Y = 10'd0,
  parameter logic [10:0] P_TGT_X   = 11'd0,
  parameter logic [9:0]  P_TGT_Y   = 10'd0,
  parameter logic [10:0] P_STEP    = 11'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic        i_tick,
  output logic [10:0] o_x,
  output logic [9:0]  o_y,
  output logic        o_arrived
);
  logic [10:0] r_x;
  logic [9:0]  r_y;
  logic [10:0] w_y_next;

  assign w_y_next = step_toward({1'b0, r_y}, {1'b0, P_TGT_Y}, P_STEP);

  always_ff @(posedge clk) begin
    if (rst || i_load) begin
      r_x <= P_START_X;
      r_y <= P_START_Y;
    end else if (i_tick) begin
      r_x <= step_toward(r_x, P_TGT_X, P_STEP);
      r_y <= w_y_next[9:0];
    end
  end

  // True when the next tick would land (or keep) the fragment exactly on target
  assign o_arrived = within_step(r_x, P_TGT_X, P_STEP) &&
                     within_step({1'b0, r_y}, {1'b0, P_TGT_Y}, P_STEP);
  assign o_x = r_x;
  assign o_y = r_y;
endmodule

// File: rtl/heart_assemble.sv
// Heart sprite built from six flying fragments; FSM IDLE->ASSEMBLE->HOLD, frame-rate motion,
// zero-latency hit test against registered fragment positions.
module heart_assemble
  import heart_assemble_pkg::*;
#(
  parameter logic [11:0] COLOR     = 12'hF00,
  parameter int          FRAG_SIZE = 32
) (
  input  logic              clk,
  input  logic              rst,
  heart_assemble_if.slave   vid
);
  state_t                r_state;
  logic                  r_done;
  logic                  w_tick;
  logic                  w_load;
  logic                  w_step;
  logic                  w_hit;
  logic [10:0]           w_x [NUM_FRAG];
  logic [9:0]            w_y [NUM_FRAG];
  logic [NUM_FRAG-1:0]   w_arrived;

  assign w_tick = vid.valid_in && (vid.hcount_in == 11'd0) && (vid.vcount_in == 10'd0);
  assign w_load = vid.start && (r_state != ASSEMBLE);
  // The load edge never steps, so a tick coinciding with start is swallowed
  assign w_step = w_tick && (r_state == ASSEMBLE);

  for (genvar g = 0; g < NUM_FRAG; g++) begin : g_frag
    heart_fragment_mover #(
      .P_START_X (START_X[g]),
      .P_START_Y (START_Y[g]),
      .P_TGT_X   (TGT_X[g]),
      .P_TGT_Y   (TGT_Y[g]),
      .P_STEP    (STEP[g])
    ) u_mover (
      .clk       (clk),
      .rst       (rst),
      .i_load    (w_load),
      .i_tick    (w_step),
      .o_x       (w_x[g]),
      .o_y       (w_y[g]),
      .o_arrived (w_arrived[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (vid.start) r_state <= ASSEMBLE;
        ASSEMBLE: if (w_step && (&w_arrived)) begin
          r_state <= HOLD;
          r_done  <= 1'b1;
        end
        HOLD: if (vid.start) begin
          r_state <= ASSEMBLE;
          r_done  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Widened compares so x+FRAG_SIZE near the raster edge cannot wrap
  always_comb begin
    w_hit = 1'b0;
    for (int i = 0; i < NUM_FRAG; i++) begin
      if ((vid.hcount_in >= w_x[i]) &&
          ({1'b0, vid.hcount_in} < ({1'b0, w_x[i]} + 12'(FRAG_SIZE))) &&
          (vid.vcount_in >= w_y[i]) &&
          ({1'b0, vid.vcount_in} < ({1'b0, w_y[i]} + 11'(FRAG_SIZE))))
        w_hit = 1'b1;
    end
  end

  assign vid.in_sprite = vid.valid_in && (r_state != IDLE) && w_hit;
  assign vid.pixel_out = vid.in_sprite ? COLOR : 12'h000;
  assign vid.done      = r_done;
endmodule

// File: tb/tb_heart_assemble.sv
`timescale 1ns/1ps
module tb_heart_assemble;
  logic clk;
  logic rst;
  heart_assemble_if vif();

  heart_assemble dut (.clk(clk), .rst(rst), .vid(vif));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;
  int tick_n = 0;

  // Reference model: fragment table straight from the description
  int sx [6] = '{0, 992, 0, 496, 992, 496};
  int sy [6] = '{0, 0, 384, 0, 384, 736};
  int tx [6] = '{464, 528, 464, 496, 528, 496};
  int ty [6] = '{352, 352, 384, 384, 384, 416};
  int st [6] = '{4, 4, 8, 4, 8, 2};
  int mx [6];
  int my [6];
  int mstate;   // 0 idle, 1 assembling, 2 holding
  bit mdone;

  function automatic int mstep(int p, int t, int s);
    if (t > p) return (t - p <= s) ? t : p + s;
    else       return (p - t <= s) ? t : p - s;
  endfunction

  task automatic model_load();
    for (int i = 0; i < 6; i++) begin
      mx[i] = sx[i];
      my[i] = sy[i];
    end
  endtask

  task automatic model_advance();
    bit all_in;
    all_in = 1'b1;
    for (int i = 0; i < 6; i++) begin
      mx[i] = mstep(mx[i], tx[i], st[i]);
      my[i] = mstep(my[i], ty[i], st[i]);
      if (mx[i] != tx[i] || my[i] != ty[i]) all_in = 1'b0;
    end
    if (all_in) begin
      mstate = 2;
      mdone  = 1'b1;
    end
  endtask

  function automatic bit model_hit(int h, int v, bit val);
    if (!val || mstate == 0) return 1'b0;
    for (int i = 0; i < 6; i++)
      if (h >= mx[i] && h < mx[i] + 32 && v >= my[i] && v < my[i] + 32) return 1'b1;
    return 1'b0;
  endfunction

  // One clock edge with the given raster inputs; model follows the edge, done compared after it
  task automatic cycle(int h, int v, bit val, bit s);
    bit is_tick;
    @(negedge clk);
    vif.hcount_in = 11'(h);
    vif.vcount_in = 10'(v);
    vif.valid_in  = val;
    vif.start     = s;
    is_tick = val && h == 0 && v == 0;
    @(posedge clk);
    if (s && mstate != 1) begin
      model_load();
      mstate = 1;
      mdone  = 1'b0;
    end else if (is_tick && mstate == 1) begin
      model_advance();
    end
    #1;
    vif.start = 1'b0;
    vif.valid_in = 1'b0;
    checks++;
    if (vif.done !== mdone) begin
      errors++;
      $display("FAIL done_track tick=%0d got=%b exp=%b", tick_n, vif.done, mdone);
    end
  endtask

  task automatic probe(int h, int v, bit val, string name);
    bit exp;
    if (h == 0 && v == 0) h = 1;
    @(negedge clk);
    vif.hcount_in = 11'(h);
    vif.vcount_in = 10'(v);
    vif.valid_in  = val;
    vif.start     = 1'b0;
    #1;
    exp = model_hit(h, v, val);
    checks++;
    if (vif.in_sprite !== exp || vif.pixel_out !== (exp ? 12'hF00 : 12'h000)) begin
      errors++;
      $display("FAIL %s (%0d,%0d) tick=%0d in_sprite=%b pixel=%h exp_in=%b", name, h, v, tick_n,
               vif.in_sprite, vif.pixel_out, exp);
    end
  endtask

  task automatic hard_probe(int h, int v, bit exp, string name);
    probe(h, v, 1'b1, name);
    checks++;
    if (vif.in_sprite !== exp) begin
      errors++;
      $display("FAIL %s hard (%0d,%0d) got=%b exp=%b", name, h, v, vif.in_sprite, exp);
    end
  endtask

  task automatic check_frag(int i);
    probe(mx[i], my[i], 1'b1, "frag_corner");
    probe(mx[i] + 31, my[i] + 31, 1'b1, "frag_far_corner");
    if (mx[i] + 32 < 1024) probe(mx[i] + 32, my[i], 1'b1, "frag_right_edge");
    if (my[i] + 32 < 768)  probe(mx[i], my[i] + 32, 1'b1, "frag_bottom_edge");
    if (mx[i] > 0) probe(mx[i] - 1, my[i], 1'b1, "frag_left_edge");
    if (my[i] > 0) probe(mx[i], my[i] - 1, 1'b1, "frag_top_edge");
  endtask

  task automatic one_tick(bit s);
    if ($urandom_range(0, 7) == 0) cycle(0, 0, 1'b0, 1'b0);   // invalid tick: no motion
    cycle(0, 0, 1'b1, s);
    tick_n++;
    probe($urandom_range(0, 1023), $urandom_range(0, 767), $urandom_range(0, 5) != 0, "rand_pixel");
    begin
      int f;
      f = $urandom_range(0, 5);
      probe(mx[f] + $urandom_range(0, 33) - 1, my[f] + $urandom_range(0, 33) - 1, 1'b1, "near_frag");
    end
  endtask

  task automatic check_done_edge();
    if (tick_n == 159 || tick_n == 160) begin
      checks++;
      if (vif.done !== (tick_n == 160)) begin
        errors++;
        $display("FAIL done_rise tick=%0d got=%b exp=%b", tick_n, vif.done, tick_n == 160);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    vif.hcount_in = '0; vif.vcount_in = '0; vif.valid_in = 1'b0; vif.start = 1'b0;
    mstate = 0; mdone = 1'b0; model_load();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (vif.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_done got=%b exp=0", vif.done);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int v = 8; v < 768; v += 48)
      for (int h = 8; h < 1024; h += 48)
        probe(h + $urandom_range(0, 15), v + $urandom_range(0, 15), 1'b1, "idle_scan");
    hard_probe(470, 360, 1'b0, "idle_centre");
    checks++;
    if (vif.pixel_out !== 12'h000) begin
      errors++;
      $display("FAIL idle_pixel got=%h exp=000", vif.pixel_out);
    end
  endtask

  task automatic test_first_tick();
    cycle(0, 0, 1'b1, 1'b1);          // start coincident with a tick: load only
    tick_n = 0;
    hard_probe(2, 2, 1'b1, "start_no_step");
    cycle(0, 0, 1'b0, 1'b0);
    hard_probe(2, 2, 1'b1, "invalid_tick");
    cycle(0, 0, 1'b1, 1'b0);
    tick_n = 1;
    hard_probe(5, 5, 1'b1, "first_tick_in");
    checks++;
    if (vif.pixel_out !== 12'hF00) begin
      errors++;
      $display("FAIL first_tick_pixel got=%h exp=f00", vif.pixel_out);
    end
    hard_probe(2, 2, 1'b0, "first_tick_out");
  endtask

  task automatic test_assemble();
    while (tick_n < 160) begin
      one_tick(tick_n == 29);          // start at tick 30 is ignored
      check_done_edge();
      if (tick_n >= 58 && (tick_n % 17 == 0 || tick_n == 58 || tick_n == 160)) check_frag(2);
    end
  endtask

  task automatic test_hold();
    for (int r = 0; r < 2; r++) begin
      hard_probe(500, 360, 1'b0, "hold_notch");
      hard_probe(470, 360, 1'b1, "hold_f0");
      hard_probe(500, 440, 1'b1, "hold_f5");
      hard_probe(560, 440, 1'b0, "hold_outside");
      for (int i = 0; i < 6; i++) check_frag(i);
      if (r == 0) repeat (10) one_tick(1'b0);
    end
  endtask

  task automatic test_restart();
    cycle(5, 5, 1'b0, 1'b1);
    tick_n = 0;
    checks++;
    if (vif.done !== 1'b0) begin
      errors++;
      $display("FAIL restart_done got=%b exp=0", vif.done);
    end
    hard_probe(496, 736, 1'b1, "restart_f5");
    hard_probe(495, 736, 1'b0, "restart_f5_left");
    check_frag(5);
    while (tick_n < 80) one_tick(1'b0);
    @(negedge clk);
    rst = 1'b1;
    vif.start = 1'b1;
    @(posedge clk);
    #1;
    mstate = 0; mdone = 1'b0; model_load();
    rst = 1'b0;
    vif.start = 1'b0;
    checks++;
    if (vif.done !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid done=%b exp=0", vif.done);
    end
    hard_probe(496, 736, 1'b0, "rst_idle_blank");
    hard_probe(470, 360, 1'b0, "rst_idle_centre");
    cycle(5, 5, 1'b0, 1'b1);
    tick_n = 0;
    check_frag(0);
    while (tick_n < 160) begin
      one_tick(1'b0);
      check_done_edge();
    end
  endtask

  initial begin
    test_reset();
    test_first_tick();
    test_assemble();
    test_hold();
    test_restart();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/heart_assemble.md
# heart_assemble

Animated heart that builds itself from six fragments. After a `start` pulse, each fragment flies in from a fixed off-centre start point and converges on its slot around screen centre (512,384) of the 1024x768 raster. Motion advances once per video frame. The block then holds the finished heart and asserts `done`. It sits beside the other sprite generators and feeds the pixel mixer with `in_sprite`/`pixel_out`.

## Interface
- `COLOR`, default 12'hF00: RGB444 colour of every fragment.
- `FRAG_SIZE`, default 32: fragment edge length in pixels (square).

- `clk`  in  1  pixel clock
- `rst`  in  1  reset, synchronous, active-high
- `hcount_in`  in  11  current pixel column
- `vcount_in`  in  10  current pixel row
- `valid_in`  in  1  hcount/vcount are in active video
- `start`  in  1  single-cycle request to (re)start assembly
- `in_sprite`  out  1  current pixel lies in a drawn fragment
- `pixel_out`  out  12  COLOR when in_sprite, else 0
- `done`  out  1  heart fully assembled (level, registered)

## Operation
- Frame tick = `valid_in && hcount_in==0 && vcount_in==0`. Positions change only on ticks.
- Fragment table, top-left (x,y) given as start -> target, step in px/tick on both axes:
  - f0: (0,0) -> (464,352), step 4
  - f1: (992,0) -> (528,352), step 4
  - f2: (0,384) -> (464,384), step 8
  - f3: (496,0) -> (496,384), step 4
  - f4: (992,384) -> (528,384), step 8
  - f5: (496,736) -> (496,416), step 2
  - (496,352) stays empty; this is the heart notch.
- Per axis, per tick:
  - if |target − pos| ≤ step, pos <= target;
  - else pos moves `step` toward target.
  - Never overshoot. A fragment at its target stays there.
- States:
  - IDLE (reset): nothing drawn, done=0.
  - ASSEMBLE: fragments drawn and stepping.
  - HOLD: heart drawn static, done=1.
- IDLE + start -> ASSEMBLE. All positions are loaded with start values at that edge, and no step is applied on that cycle even if it is also a tick.
- ASSEMBLE: on the tick where every fragment's next position equals its target, state moves to HOLD and done goes to 1 on the same edge that writes the final positions. start is ignored in ASSEMBLE.
- HOLD + start -> ASSEMBLE with start positions reloaded; done goes to 0 on that edge.
- Hit test, combinational, unsigned:
  - `x ≤ hcount_in < x+FRAG_SIZE` and `y ≤ vcount_in < y+FRAG_SIZE`;
  - evaluate the sums at 12/11 bits so they cannot wrap.
- in_sprite = valid_in && state≠IDLE && any fragment hit. pixel_out = in_sprite ? COLOR : 0.
- Overlapping fragments simply OR together.

## Timing
- Reset values: state IDLE, done 0, positions = start table, in_sprite 0, pixel_out 0.
- in_sprite/pixel_out have zero latency from hcount/vcount; they use the registered positions.
- A new position is visible starting the cycle after its tick edge.
- Arrival ticks after start: f2 and f4 at 58; f3 at 96; f0 and f1 at 116; f5 at 160. done rises at tick 160.
- A tick with valid_in low does not count and produces no step.
- rst mid-assembly returns to IDLE on the next edge; rst overrides start.

## Structure
- Package `heart_assemble_pkg` holds:
  - NUM_FRAG=6;
  - start/target/step constant arrays;
  - CENTER_X/CENTER_Y;
  - state enum {IDLE, ASSEMBLE, HOLD}.
- Sub-module `heart_fragment_mover`, instantiated 6× with per-instance start/target/step parameters:
  - inputs load, tick;
  - outputs x, y, arrived.
- The top level owns the FSM, the OR of arrived signals, and the hit test.

## Test plan
- Reset, then scan the frame: in_sprite=0 everywhere, done=0, pixel_out=0 at (470,360).
- start, then one tick:
  - f0 is at (4,4), so pixel (5,5) gives in_sprite=1 and pixel_out=12'hF00;
  - pixel (2,2) gives 0.
- Run 160 ticks:
  - f2 is (464,384) from tick 58 onward, unchanged through tick 160;
  - done=0 after tick 159 and done=1 after tick 160.
- HOLD pixels: (500,360) → 0 (notch); (470,360) → 1; (500,440) → 1; (560,440) → 0. Outputs stay stable over 10 more frames.
- start pulse at tick 30: no effect, and done still rises at tick 160. start in HOLD: done=0 next cycle and f5 is back at (496,736).
- rst at tick 80: IDLE and done=0 next cycle. A later start reloads start positions and done again needs 160 ticks.
